// File: rtl/pwm_sequencer.sv
// rtl/pwm_sequencer.sv - phase sequencer, soft-start PWM and full-scale fault shutdown for the duty-cycle store
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   enable     : run request (level)
//   dc_control : duty level from the store, latched once per frame
//   trigger    : 3-bit phase counter to the store
//   store_clr  : active-high clear to the store
//   pwm_out    : PWM drive, min(latched duty, ramp limit) of 8 phases
//   running    : high in RUN
//   fault      : high in FAULT

module pwm_sequencer #(
    parameter int PRESCALE     = 4,
    parameter int FAULT_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] dc_control,
    output logic [2:0] trigger,
    output logic       store_clr,
    output logic       pwm_out,
    output logic       running,
    output logic       fault
);

    localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [3:0]      FAULT_LIM = 4'(FAULT_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_FAULT
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      trig_q, trig_d;
    logic [2:0]      duty_q, duty_d;
    logic [2:0]      ramp_q, ramp_d;
    logic [3:0]      fcnt_q, fcnt_d;
    logic            arm_first_q, arm_first_d;

    logic            tick;
    logic            frame_end;
    logic [3:0]      fcnt_next;
    logic            trip;
    logic [2:0]      eff_duty;

    assign tick      = (presc_q == PRESC_MAX);
    assign frame_end = tick && (trig_q == 3'd7);

    // Fault count is judged on the value being latched at this frame end.
    assign fcnt_next = (dc_control != 3'd7) ? 4'd0 :
                       (fcnt_q == 4'd15)    ? 4'd15 : (fcnt_q + 4'd1);
    assign trip      = (fcnt_next == FAULT_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            trig_q      <= 3'd0;
            duty_q      <= 3'd0;
            ramp_q      <= 3'd0;
            fcnt_q      <= 4'd0;
            arm_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            trig_q      <= trig_d;
            duty_q      <= duty_d;
            ramp_q      <= ramp_d;
            fcnt_q      <= fcnt_d;
            arm_first_q <= arm_first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        trig_d      = trig_q;
        duty_d      = duty_q;
        ramp_d      = ramp_q;
        fcnt_d      = fcnt_q;
        arm_first_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                presc_d = '0;
                trig_d  = 3'd0;
                duty_d  = 3'd0;
                ramp_d  = 3'd0;
                fcnt_d  = 4'd0;
                if (enable) begin
                    state_d     = S_ARM;
                    arm_first_d = 1'b1;
                end
            end

            S_ARM, S_RUN: begin
                if (!enable) begin
                    // A dropped enable overrides any frame-end action on this edge.
                    state_d = S_IDLE;
                    presc_d = '0;
                    trig_d  = 3'd0;
                    duty_d  = 3'd0;
                    ramp_d  = 3'd0;
                    fcnt_d  = 4'd0;
                end else begin
                    presc_d = tick ? '0 : (presc_q + PW'(1));
                    if (tick) begin
                        trig_d = trig_q + 3'd1;
                    end
                    if (frame_end) begin
                        fcnt_d = fcnt_next;
                        if (trip) begin
                            // Duty is not updated: the full-scale value is discarded.
                            state_d = S_FAULT;
                            presc_d = '0;
                            trig_d  = 3'd0;
                        end else begin
                            state_d = S_RUN;
                            duty_d  = dc_control;
                            // Ramp starts at 0 for the first RUN frame.
                            if (state_q == S_ARM) begin
                                ramp_d = 3'd0;
                            end else if (ramp_q != 3'd7) begin
                                ramp_d = ramp_q + 3'd1;
                            end
                        end
                    end
                end
            end

            S_FAULT: begin
                presc_d = '0;
                trig_d  = 3'd0;
                if (!enable) begin
                    state_d = S_IDLE;
                    duty_d  = 3'd0;
                    ramp_d  = 3'd0;
                    fcnt_d  = 4'd0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign eff_duty  = (duty_q < ramp_q) ? duty_q : ramp_q;

    // All outputs decode registered state only, so reset reaches them without a clock.
    assign trigger   = trig_q;
    assign running   = (state_q == S_RUN);
    assign fault     = (state_q == S_FAULT);
    assign store_clr = (state_q == S_IDLE) || (state_q == S_FAULT) ||
                       ((state_q == S_ARM) && arm_first_q);
    assign pwm_out   = (state_q == S_RUN) && (trig_q < eff_duty);

endmodule

// File: tb/tb_pwm_sequencer.sv
// tb/tb_pwm_sequencer.sv - self-checking bench for pwm_sequencer

module tb_pwm_sequencer;

    localparam int P  = 2;
    localparam int FF = 3;
    localparam int FL = 8 * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] dc_control = 3'd0;
    logic [2:0] trigger;
    logic       store_clr;
    logic       pwm_out;
    logic       running;
    logic       fault;

    int errors = 0;
    int checks = 0;

    pwm_sequencer #(.PRESCALE(P), .FAULT_FRAMES(FF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .dc_control (dc_control),
        .trigger    (trigger),
        .store_clr  (store_clr),
        .pwm_out    (pwm_out),
        .running    (running),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 arm, 2 run, 3 fault; m_cyc is the cycle within the frame.
    int m_mode = 0;
    int m_cyc = 0;
    int m_duty = 0;
    int m_ramp = 0;
    int m_fc = 0;
    bit m_first = 1'b0;

    function automatic int fc_after(input int fc, input int dc);
        if (dc != 7) return 0;
        return (fc < 15) ? fc + 1 : 15;
    endfunction

    function automatic int e_trig();
        return (m_mode == 1 || m_mode == 2) ? m_cyc / P : 0;
    endfunction

    function automatic int e_pwm();
        int eff;
        eff = (m_duty < m_ramp) ? m_duty : m_ramp;
        return (m_mode == 2 && e_trig() < eff) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_cyc <= 0; m_duty <= 0; m_ramp <= 0; m_fc <= 0; m_first <= 1'b0;
        end else if (!enable) begin
            m_mode <= 0; m_cyc <= 0; m_duty <= 0; m_ramp <= 0; m_fc <= 0; m_first <= 1'b0;
        end else begin
            m_first <= 1'b0;
            case (m_mode)
                0: begin
                    m_mode  <= 1;
                    m_cyc   <= 0;
                    m_first <= 1'b1;
                end
                1, 2: begin
                    if (m_cyc == FL - 1) begin
                        m_cyc <= 0;
                        m_fc  <= fc_after(m_fc, int'(dc_control));
                        if (fc_after(m_fc, int'(dc_control)) == FF) begin
                            m_mode <= 3;
                        end else begin
                            m_mode <= 2;
                            m_duty <= int'(dc_control);
                            m_ramp <= (m_mode == 1) ? 0 : ((m_ramp < 7) ? m_ramp + 1 : 7);
                        end
                    end else begin
                        m_cyc <= m_cyc + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("trigger", int'(trigger), e_trig());
        chk("pwm_out", int'(pwm_out), e_pwm());
        chk("store_clr", int'(store_clr),
            (m_mode == 0 || m_mode == 3 || (m_mode == 1 && m_first)) ? 1 : 0);
        chk("running", int'(running), (m_mode == 2) ? 1 : 0);
        chk("fault", int'(fault), (m_mode == 3) ? 1 : 0);
    end

    task automatic step();
        @(negedge clk);
    endtask

    int exp_hi[8] = '{0, 1, 2, 3, 4, 5, 5, 5};
    int seq[5]    = '{7, 7, 6, 7, 7};

    initial begin
        int clr_cnt, run_cnt, pwm_cnt, hi, n;

        dc_control = 3'd5;
        repeat (3) step();
        chk("reset_store_clr", int'(store_clr), 1);
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_trigger", int'(trigger), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_fault", int'(fault), 0);
        rst_n = 1'b1;
        repeat (4) step();
        chk("idle_store_clr", int'(store_clr), 1);

        // Start-up: one-cycle clear pulse, 16-cycle ARM, soft-start ramp.
        enable = 1'b1;
        clr_cnt = 0; run_cnt = 0; pwm_cnt = 0;
        for (int k = 1; k <= FL; k++) begin
            step();
            if (k == 1) chk("arm_first_clr", int'(store_clr), 1);
            clr_cnt += int'(store_clr);
            run_cnt += int'(running);
            pwm_cnt += int'(pwm_out);
        end
        chk("arm_clr_cycles", clr_cnt, 1);
        chk("arm_run_cycles", run_cnt, 0);
        chk("arm_pwm_cycles", pwm_cnt, 0);
        for (int f = 0; f < 8; f++) begin
            hi = 0;
            for (int i = 0; i < FL; i++) begin
                step();
                if (f == 0 && i == 0) chk("run_entry", int'(running), 1);
                hi += int'(pwm_out);
            end
            chk($sformatf("ramp_frame%0d", f), hi, P * exp_hi[f]);
            if (f == 7) dc_control = 3'd3;
        end

        // Steady state duty 3: 6 high, 10 low, trigger held 2 cycles each.
        for (int i = 0; i < FL; i++) begin
            step();
            chk("steady_pwm", int'(pwm_out), (i < 6) ? 1 : 0);
            chk("steady_trig", int'(trigger), i / 2);
        end

        // Enable dropped mid-frame.
        repeat (5) step();
        enable = 1'b0;
        step();
        chk("drop_trig", int'(trigger), 0);
        chk("drop_pwm", int'(pwm_out), 0);
        chk("drop_running", int'(running), 0);
        chk("drop_store_clr", int'(store_clr), 1);

        // Fault on 3rd consecutive latch of 7 (ARM latch counts).
        dc_control = 3'd7;
        enable = 1'b1;
        n = 0;
        while (!fault && n < 200) begin
            step();
            n++;
        end
        chk("fault_latency", n, 3 * FL + 1);
        chk("fault_pwm", int'(pwm_out), 0);
        chk("fault_store_clr", int'(store_clr), 1);
        chk("fault_trig", int'(trigger), 0);
        enable = 1'b0;
        step();
        chk("fault_exit", int'(fault), 0);
        chk("fault_exit_clr", int'(store_clr), 1);

        // Non-consecutive full scale: 7,7,6,7,7 must not trip; a further 7 must.
        enable = 1'b1;
        repeat (FL - 1) step();
        for (int j = 0; j < 5; j++) begin
            dc_control = 3'(seq[j]);
            repeat (FL) step();
        end
        chk("nonconsec_fault", int'(fault), 0);
        chk("nonconsec_running", int'(running), 1);
        dc_control = 3'd7;
        repeat (FL) step();
        chk("third_seven_fault", int'(fault), 1);

        // Asynchronous reset in the middle of a RUN cycle.
        enable = 1'b0;
        step();
        dc_control = 3'd5;
        enable = 1'b1;
        repeat (FL + 4 * FL + 3) step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_store_clr", int'(store_clr), 1);
        chk("async_pwm", int'(pwm_out), 0);
        chk("async_running", int'(running), 0);
        chk("async_trig", int'(trigger), 0);
        step();
        rst_n = 1'b1;

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            step();
            enable = ($urandom_range(0, 199) != 0);
            dc_control = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'($urandom_range(0, 7));
            if (i == 1000 || i == 2000) begin
                #2 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_sequencer.md
# pwm_sequencer

Sequencing controller for the duty-cycle store. It generates the 3-bit `trigger` phase that tells the store when to sample `current`, and clears the store on start-up. Once per frame it latches the store's `dc_control` and turns it into a soft-started PWM drive. It also detects a sustained full-scale duty condition and shuts the output down.

## Interface
- `PRESCALE`, default 4: clock cycles per phase tick; legal range 1..256.
- `FAULT_FRAMES`, default 3: consecutive frames at duty 7 that trip a fault; legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `enable` input 1: run request; level-sensitive.
- `dc_control` input 3: duty level from the store.
- `trigger` output 3: phase counter driven to the store's `trigger`.
- `store_clr` output 1: active-high clear, driven to the store's `rst`.
- `pwm_out` output 1: PWM drive.
- `running` output 1: high in RUN.
- `fault` output 1: high in FAULT.

## Operation
- Reset values: state IDLE, prescaler 0, `trigger` 0, latched duty 0, ramp limit 0, fault count 0.
  - Outputs at reset: `store_clr` 1, `pwm_out` 0, `running` 0, `fault` 0.
- Prescaler:
  - Counts 0..PRESCALE-1 in ARM and RUN; held at 0 in IDLE and FAULT.
  - `tick` = prescaler == PRESCALE-1.
- Phase counter (`trigger`):
  - Increments on `tick`, wrapping 7 -> 0.
  - A frame end is a `tick` with `trigger` == 7.
  - Forced to 0 in IDLE and FAULT.
- States:
  - IDLE: `store_clr` 1; all counters cleared. Goes to ARM when `enable` = 1.
  - ARM: `store_clr` 1 for the first cycle only, then 0; `pwm_out` 0. Lasts exactly one frame; goes to RUN on frame end.
  - RUN: `running` 1; `pwm_out` active. Goes to FAULT on trip.
  - FAULT: `fault` 1; `pwm_out` 0; `store_clr` 1. Goes to IDLE when `enable` = 0.
- `enable` = 0 in ARM or RUN: next edge goes to IDLE; counters are cleared on that edge.
- Frame-end actions, all on the same edge:
  - Latch `dc_control` into the duty register; this happens at ARM->RUN and at every RUN frame end.
  - Ramp limit: increments by 1 at each RUN frame end, saturating at 7. It is 0 on entry to RUN, so the first RUN frame has ramp limit 0.
  - Fault count:
    - Compared value is the `dc_control` being latched on this edge.
    - If it is 7: count increments, saturating at 15. Otherwise count clears to 0.
    - Trip condition: the incremented count reaches FAULT_FRAMES.
    - On trip: next state is FAULT and the new duty is discarded.
- Effective duty = min(latched duty, ramp limit); 3-bit unsigned compare.
- `pwm_out` = (state == RUN) && (`trigger` < effective duty).
  - Decoded only from registers, with no input-to-output combinational path.
  - Duty d gives high for d of 8 phases; duty 0 gives constant low.
- The ARM count also feeds the fault counter (checked from the ARM->RUN latch onward).

## Timing
- `trigger` changes only on a `tick` edge and holds each value for PRESCALE cycles.
- Latency from a `dc_control` change to `pwm_out`:
  - Takes effect at the next frame end.
  - Worst case 8*PRESCALE cycles plus the ramp limit.
- `pwm_out` phase: rises on the edge that sets `trigger` to 0 (when effective duty > 0). Falls on the edge where `trigger` becomes equal to effective duty.
- `store_clr` in ARM: high exactly 1 cycle, the cycle after the IDLE->ARM edge.
- Reset mid-frame:
  - All outputs go to their reset values immediately, without waiting for a clock.
  - Resuming after `rst_n` rises starts from IDLE.
- Simultaneous `enable` drop and frame end: `enable` wins. Go to IDLE; no latch, no fault count update.
- Simultaneous trip and `enable` drop: go to IDLE, not FAULT.

## Test plan
- Start-up, PRESCALE=2, `dc_control` held at 5:
  - `store_clr` stays high through IDLE, then is high for exactly 1 cycle after `enable` rises.
  - ARM lasts 16 cycles with `pwm_out` 0.
  - In RUN, `pwm_out` high phases per frame are 0, 1, 2, 3, 4, 5, 5, 5.
- Steady state, duty 3 after ramp complete: `pwm_out` high for 6 cycles and low for 10, repeating; `trigger` sequence is 0..7, each value held 2 cycles.
- Fault, FAULT_FRAMES=3, `dc_control` = 7:
  - Fault count includes the ARM->RUN latch.
  - FAULT is entered at the 2nd RUN frame end, i.e. the 3rd consecutive latch of 7.
  - On entry: `fault` 1, `pwm_out` 0, `store_clr` 1, `trigger` 0.
  - Dropping `enable` returns to IDLE.
- Non-consecutive full scale: latches of 7, 7, 6, 7, 7 -> no fault.
- `enable` dropped mid-frame in RUN: next edge gives IDLE, `trigger` 0, `pwm_out` 0. Re-enable repeats ARM and the ramp restarts from 0.
- Async reset asserted mid-cycle in RUN: outputs go to their reset values before the next clock edge; no glitch on `pwm_out` after release.
